// File: rtl/mem_pkg.sv
// Shared definitions for the mem_handle responder: word width, default
// address width and the responder sequencing states.
package mem_pkg;

    localparam int WORD_W     = 32;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT     = 2'd2,
        COMPLETE = 2'd3
    } resp_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_handle bundle for NUM_PORTS initiators. The master side (compute
// units) drives requests and region bounds; the slave side (mem_responder)
// returns level-held done, read data and the bounds error flag.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = DEF_ADDR_W
);

    logic [NUM_PORTS-1:0]              avail;
    logic [NUM_PORTS-1:0]              r_en;
    logic [NUM_PORTS-1:0]              w_en;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  ptr;
    logic [NUM_PORTS-1:0][WORD_W-1:0]  data_store;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  region_begin;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  region_end;
    logic [NUM_PORTS-1:0]              done;
    logic [NUM_PORTS-1:0][WORD_W-1:0]  data_load;
    logic [NUM_PORTS-1:0]              err;

    modport master (
        output avail, r_en, w_en, ptr, data_store, region_begin, region_end,
        input  done, data_load, err
    );

    modport slave (
        input  avail, r_en, w_en, ptr, data_store, region_begin, region_end,
        output done, data_load, err
    );

endinterface

// File: rtl/mem_sram.sv
// Single-port word SRAM: synchronous write, READ_LATENCY-stage registered
// read. The first read stage only loads on a read, so the returned word
// stays on o_rdata until the next read has propagated through.
module mem_sram
    import mem_pkg::*;
#(
    parameter int DEPTH        = 4096,
    parameter int ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem     [DEPTH];
    logic [WORD_W-1:0] r_rd_pipe [READ_LATENCY];

    // Write port: commit on the clock edge of a write access.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // First read stage: capture the addressed word on a read access only.
    always_ff @(posedge clk) begin
        if (i_en && !i_we) begin
            r_rd_pipe[0] <= r_mem[i_addr];
        end
    end

    // Remaining read stages: plain delay line toward the output.
    always_ff @(posedge clk) begin
        for (int k = 1; k < READ_LATENCY; k++) begin
            r_rd_pipe[k] <= r_rd_pipe[k-1];
        end
    end

    assign o_rdata = r_rd_pipe[READ_LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the mem_handle protocol. Round-robin arbitration over
// NUM_PORTS initiators, one access at a time against mem_sram, with a
// level-held done per port that clears once that port drops avail.
// Optional build macro MEM_RESPONDER_BOUNDS_CHECK_EN enables per-port
// region checking: an out-of-region pointer skips the SRAM access and
// completes with data_load=0 and err=1. Without it, err is tied low.
module mem_responder
    import mem_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave mem_if
);

    localparam int SEL_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);

    resp_state_t                      r_state;
    logic [SEL_W-1:0]                 r_rr_ptr;
    logic [SEL_W-1:0]                 r_gnt;
    logic [MEM_AW-1:0]                r_addr;
    logic [WORD_W-1:0]                r_wdata;
    logic                             r_is_wr;
    logic                             r_oob;
    logic [LAT_W-1:0]                 r_lat_cnt;
    logic [NUM_PORTS-1:0]             r_done;
    logic [NUM_PORTS-1:0][WORD_W-1:0] r_data_load;

    logic [NUM_PORTS-1:0]             w_elig;
    logic                             w_any_elig;
    logic [SEL_W-1:0]                 w_pick;
    logic [NUM_PORTS-1:0]             w_oob;
    logic                             w_sram_en;
    logic [WORD_W-1:0]                w_sram_rdata;

    // Round-robin search starting just above the last granted port.
    // Returns {found, index}.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [NUM_PORTS-1:0] elig,
        input logic [SEL_W-1:0]     last
    );
        logic [SEL_W:0] res;
        int             idx;
        res = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last) + k) % NUM_PORTS;
            if (!res[SEL_W] && elig[idx]) begin
                res = {1'b1, SEL_W'(idx)};
            end
        end
        return res;
    endfunction

    // A port holding done is excluded so it is not served twice per request.
    assign w_elig = mem_if.avail & (mem_if.r_en | mem_if.w_en) & ~r_done;
    assign {w_any_elig, w_pick} = rr_pick(w_elig, r_rr_ptr);

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    // Region test per port: begin inclusive, end exclusive, full-width ptr.
    always_comb begin
        w_oob = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_oob[i] = (mem_if.ptr[i] < mem_if.region_begin[i]) ||
                       (mem_if.ptr[i] >= mem_if.region_end[i]);
        end
    end
`else
    logic w_unused_bounds;
    assign w_oob           = '0;
    assign w_unused_bounds = ^{mem_if.region_begin, mem_if.region_end, mem_if.ptr};
`endif

    // Responder sequencing: grant and latch, drive SRAM, wait out latency, complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rr_ptr  <= SEL_W'(NUM_PORTS - 1);
            r_gnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_is_wr   <= 1'b0;
            r_oob     <= 1'b0;
            r_lat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_elig) begin
                        r_gnt    <= w_pick;
                        r_rr_ptr <= w_pick;
                        r_addr   <= mem_if.ptr[w_pick][MEM_AW-1:0];
                        r_wdata  <= mem_if.data_store[w_pick];
                        r_is_wr  <= mem_if.w_en[w_pick];
                        r_oob    <= w_oob[w_pick];
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_lat_cnt <= LAT_W'(READ_LATENCY);
                    r_state   <= WAIT;
                end
                WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 1'b1;
                    if (r_lat_cnt == LAT_W'(1)) begin
                        r_state <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The SRAM sees the access only in ISSUE; a rejected pointer never touches it.
    assign w_sram_en = (r_state == ISSUE) && !r_oob;

    mem_sram #(
        .DEPTH        (DEPTH),
        .ADDR_W       (MEM_AW),
        .READ_LATENCY (READ_LATENCY)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_sram_en),
        .i_we    (r_is_wr),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_sram_rdata)
    );

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    logic [NUM_PORTS-1:0] r_err;
`endif

    // Per-port completion: set on COMPLETE for the granted port (which wins
    // over a same-edge avail drop), otherwise cleared when avail is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done      <= '0;
            r_data_load <= '0;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
            r_err       <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((r_state == COMPLETE) && (r_gnt == SEL_W'(i))) begin
                    r_done[i]      <= 1'b1;
                    r_data_load[i] <= r_oob   ? '0      :
                                      r_is_wr ? r_wdata : w_sram_rdata;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
                    r_err[i]       <= r_oob;
`endif
                end else if (!mem_if.avail[i]) begin
                    r_done[i] <= 1'b0;
                end
            end
        end
    end

    assign mem_if.done      = r_done;
    assign mem_if.data_load = r_data_load;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    assign mem_if.err       = r_err;
`else
    assign mem_if.err       = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed protocol scenarios followed by a
// randomized multi-port phase, all checked against a word-array memory
// model and the protocol's timing/ordering rules.
// Honours MEM_RESPONDER_BOUNDS_CHECK_EN for the region-check scenario.
module tb_mem_responder;

    localparam int NP      = 4;
    localparam int AW      = 16;
    localparam int DEPTH   = 4096;
    localparam int RL      = 1;
    localparam int EXP_LAT = RL + 3;
    localparam int TMO     = 40;

    logic clk;
    logic rst;

    mem_responder_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

    mem_responder #(
        .NUM_PORTS    (NP),
        .ADDR_W       (AW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          ref_vld [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start(input int p, input bit wr, input logic [15:0] a, input logic [31:0] d);
        bus.avail[p]      = 1'b1;
        bus.r_en[p]       = !wr;
        bus.w_en[p]       = wr;
        bus.ptr[p]        = a;
        bus.data_store[p] = d;
    endtask

    // Drop the request, then confirm done cleared and data held.
    task automatic release_port(input int p, input logic [31:0] exp_dl);
        bus.avail[p] = 1'b0;
        bus.r_en[p]  = 1'b0;
        bus.w_en[p]  = 1'b0;
        @(negedge clk);
        check("done_clear", {31'd0, bus.done[p]}, 32'd0);
        check("dl_hold", bus.data_load[p], exp_dl);
    endtask

    // One isolated transaction with latency, data and err checks.
    task automatic txn(input int p, input bit wr, input logic [15:0] a,
                       input logic [31:0] d, input bit exp_err);
        int          lat;
        logic [31:0] exp_dl;
        logic [11:0] wa;
        wa = a[11:0];
        start(p, wr, a, d);
        lat = -1;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            if (bus.done[p]) begin
                lat = k;
                break;
            end
        end
        if (exp_err)  exp_dl = 32'd0;
        else if (wr)  exp_dl = d;
        else          exp_dl = ref_mem[wa];
        if (wr && !exp_err) begin
            ref_mem[wa] = d;
            ref_vld[wa] = 1'b1;
        end
        check("latency", lat, EXP_LAT);
        check("data_load", bus.data_load[p], exp_dl);
        check("err", {31'd0, bus.err[p]}, {31'd0, exp_err});
        release_port(p, exp_dl);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          t0, t3;
    int          order [$];
    bit          rel [NP];
    int          st [NP];
    int          wcnt [NP];
    logic [15:0] pa [NP];
    bit          pwr [NP];
    logic [31:0] pd [NP];
    logic [31:0] exp_v;

    initial begin
        bus.avail        = '0;
        bus.r_en         = '0;
        bus.w_en         = '0;
        bus.ptr          = '0;
        bus.data_store   = '0;
        bus.region_begin = '0;
        for (int p = 0; p < NP; p++) bus.region_end[p] = 16'hFFFF;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_done", {28'd0, bus.done}, 32'd0);
        check("rst_err", {28'd0, bus.err}, 32'd0);
        check("rst_dl0", bus.data_load[0], 32'd0);
        check("rst_dl3", bus.data_load[3], 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single read of a preloaded word, done held while avail held.
        txn(1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0);
        start(0, 1'b0, 16'h0010, 32'd0);
        t0 = -1;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            if (bus.done[0]) begin t0 = k; break; end
        end
        check("rd_latency", t0, EXP_LAT);
        check("rd_data", bus.data_load[0], 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        check("rd_done_held", {31'd0, bus.done[0]}, 32'd1);
        release_port(0, 32'hDEADBEEF);
        @(negedge clk);

        // Write then read on port 3; also ptr above DEPTH aliases (mod DEPTH).
        txn(3, 1'b1, 16'h0020, 32'h12345678, 1'b0);
        txn(3, 1'b0, 16'h0020, 32'd0, 1'b0);
        txn(2, 1'b0, 16'h3020, 32'd0, 1'b0);
        txn(3, 1'b1, 16'h0020, 32'h12345678, 1'b0);

        // Contention: last grant was port 3, so port 0 goes first.
        start(0, 1'b0, 16'h0010, 32'd0);
        start(3, 1'b0, 16'h0020, 32'd0);
        t0 = -1;
        t3 = -1;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            if (bus.done[0] && t0 < 0) t0 = k;
            if (bus.done[3] && t3 < 0) t3 = k;
            if (t0 >= 0 && t3 >= 0) break;
        end
        check("cont_t0", t0, EXP_LAT);
        check("cont_t3", t3, 2 * EXP_LAT);
        check("cont_both", {30'd0, bus.done[0], bus.done[3]}, 32'd3);
        check("cont_dl0", bus.data_load[0], 32'hDEADBEEF);
        check("cont_dl3", bus.data_load[3], 32'h12345678);
        release_port(0, 32'hDEADBEEF);
        release_port(3, 32'h12345678);
        repeat (2) @(negedge clk);

        // Fairness: all request, each drops avail for one cycle after done.
        order.delete();
        for (int p = 0; p < NP; p++) begin
            rel[p] = 1'b0;
            start(p, 1'b0, (p < 2) ? 16'h0010 : 16'h0020, 32'd0);
        end
        for (int cyc = 0; cyc < 200 && order.size() < 8; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (rel[p]) begin
                    bus.avail[p] = 1'b1;
                    rel[p]       = 1'b0;
                end else if (bus.avail[p] && bus.done[p]) begin
                    order.push_back(p);
                    check("fair_dl", bus.data_load[p], (p < 2) ? ref_mem[12'h010] : ref_mem[12'h020]);
                    bus.avail[p] = 1'b0;
                    rel[p]       = 1'b1;
                end
            end
        end
        check("fair_count", order.size(), 8);
        for (int j = 0; j < order.size(); j++) check("fair_order", order[j], j % NP);
        bus.avail = '0;
        bus.r_en  = '0;
        repeat (12) @(negedge clk);
        check("fair_quiet", {28'd0, bus.done}, 32'd0);

        // Reset while a write is in ISSUE: the write must not land.
        txn(2, 1'b1, 16'h0030, 32'hA5A5_0030, 1'b0);
        start(2, 1'b1, 16'h0030, 32'h5A5A_FFFF);
        @(negedge clk);
        rst          = 1'b1;
        bus.avail[2] = 1'b0;
        @(negedge clk);
        check("rst_issue_done", {28'd0, bus.done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        txn(2, 1'b0, 16'h0030, 32'd0, 1'b0);

        // Reset during WAIT with another port holding done.
        start(0, 1'b0, 16'h0010, 32'd0);
        for (int k = 0; k < EXP_LAT; k++) @(negedge clk);
        check("pre_rst_done0", {31'd0, bus.done[0]}, 32'd1);
        start(1, 1'b0, 16'h0020, 32'd0);
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        bus.avail = '0;
        @(negedge clk);
        check("rst_wait_done", {28'd0, bus.done}, 32'd0);
        check("rst_wait_dl0", bus.data_load[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        txn(1, 1'b0, 16'h0020, 32'd0, 1'b0);

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        // Region [0x100,0x200) on port 2: end is exclusive, begin inclusive.
        txn(1, 1'b1, 16'h0200, 32'hCAFE_0200, 1'b0);
        bus.region_begin[2] = 16'h0100;
        bus.region_end[2]   = 16'h0200;
        txn(2, 1'b1, 16'h0200, 32'h0000_FFFF, 1'b1);
        txn(1, 1'b0, 16'h0200, 32'd0, 1'b0);
        txn(2, 1'b1, 16'h0100, 32'h0000_0100, 1'b0);
        txn(2, 1'b0, 16'h00FF, 32'd0, 1'b1);
        bus.region_begin[2] = 16'h0000;
        bus.region_end[2]   = 16'hFFFF;
`endif

        // Randomized concurrent traffic; each port owns addresses == port mod 4.
        for (int p = 0; p < NP; p++) begin
            st[p]   = 0;
            wcnt[p] = 0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                case (st[p])
                    0: begin
                        if ($urandom_range(0, 2) == 0) begin
                            pa[p]  = {4'($urandom_range(0, 14)), 4'hA, 6'($urandom), 2'(p)};
                            pwr[p] = ($urandom_range(0, 1) == 1) || !ref_vld[pa[p][11:0]];
                            pd[p]  = $urandom;
                            if (($urandom_range(0, 3) == 0) && pwr[p]) bus.r_en[p] = 1'b1;
                            else bus.r_en[p] = !pwr[p];
                            bus.w_en[p]       = pwr[p];
                            bus.ptr[p]        = pa[p];
                            bus.data_store[p] = pd[p];
                            bus.avail[p]      = 1'b1;
                            wcnt[p] = 0;
                            st[p]   = 1;
                        end
                    end
                    1: begin
                        wcnt[p]++;
                        if (bus.done[p]) begin
                            if (pwr[p]) begin
                                ref_mem[pa[p][11:0]] = pd[p];
                                ref_vld[pa[p][11:0]] = 1'b1;
                            end
                            exp_v = ref_mem[pa[p][11:0]];
                            check("rnd_dl", bus.data_load[p], exp_v);
                            check("rnd_err", {31'd0, bus.err[p]}, 32'd0);
                            bus.avail[p] = 1'b0;
                            bus.r_en[p]  = 1'b0;
                            bus.w_en[p]  = 1'b0;
                            st[p] = 2;
                        end else if (wcnt[p] > TMO) begin
                            check("rnd_timeout", wcnt[p], TMO);
                            bus.avail[p] = 1'b0;
                            st[p] = 2;
                        end
                    end
                    default: begin
                        check("rnd_clear", {31'd0, bus.done[p]}, 32'd0);
                        st[p] = 0;
                    end
                endcase
            end
        end
        bus.avail = '0;
        repeat (12) @(negedge clk);
        check("end_quiet", {28'd0, bus.done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the mem_handle protocol; services the requests that compute units (e.g. the parameter-update FSM) issue on their handles.
- Arbitrates round-robin among NUM_PORTS initiator ports and runs one access at a time against an internal single-port SRAM.
- Returns data_load and a level-held done per port; optionally checks each pointer against that port's region bounds.

Parameters:
- NUM_PORTS, 4, number of initiator handles served (a, b, c, d)
- ADDR_W, 16, width of ptr and region bounds
- DEPTH, 4096, SRAM words (32 bits each)
- READ_LATENCY, 1, SRAM read latency in cycles (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- avail  in  NUM_PORTS  per-port request valid
- r_en  in  NUM_PORTS  per-port read request
- w_en  in  NUM_PORTS  per-port write request
- ptr  in  NUM_PORTS×ADDR_W  per-port word address
- data_store  in  NUM_PORTS×32  per-port write data
- region_begin  in  NUM_PORTS×ADDR_W  per-port region start, inclusive
- region_end  in  NUM_PORTS×ADDR_W  per-port region end, exclusive
- done  out  NUM_PORTS  per-port completion, level-held
- data_load  out  NUM_PORTS×32  per-port read data, valid while done=1
- err  out  NUM_PORTS  per-port bounds error, valid while done=1

Behaviour:
- Reset: done=0, data_load=0, err=0, FSM=IDLE, rr_ptr=NUM_PORTS-1. SRAM contents are not cleared. A reset mid-access discards the in-flight access; a write is not committed unless its SRAM write edge has already occurred.
- Eligibility: port i is eligible when avail[i] && (r_en[i]|w_en[i]) && !done[i].
- Arbitration: round-robin, searching from rr_ptr+1 upward with wrap. rr_ptr is updated to the granted port.
- Request hold: the initiator holds ptr, data_store, r_en and w_en stable from avail rising until done is seen. The responder latches them at grant.
- FSM IDLE: if any port is eligible, grant it, latch its request, go to ISSUE.
- FSM ISSUE: drive the SRAM (write if w_en, else read), load lat_cnt=READ_LATENCY, go to WAIT.
- FSM WAIT: decrement lat_cnt; at 0 go to COMPLETE.
- FSM COMPLETE: set done[g]; set data_load[g] to SRAM read data (for a write, the written data); go to IDLE.
- Latency: with FSM idle, done[i] rises exactly READ_LATENCY+3 edges after avail[i] is first sampled high. For READ_LATENCY=1 that is 4 cycles.
- Done clearing: done[i] stays high until avail[i] is sampled low, and clears on that edge. data_load[i] and err[i] hold their values until the next completion on port i.
- Concurrency: other ports continue to be served while done[i] is held. This is required so an initiator can wait for done on two handles at once.
- Simultaneous events: when avail drops on the same edge COMPLETE would set done, the done is still set and then clears on the next edge.
- Both r_en and w_en high: treated as a write.
- Addressing: SRAM address is ptr mod DEPTH (low log2(DEPTH) bits).
- An eligible port re-requesting with avail held high and done high is not re-served. The initiator must drop avail for at least one cycle between requests.

Optional Feature:
- Macro: MEM_RESPONDER_BOUNDS_CHECK_EN.
- Defined: at grant, if ptr<region_begin or ptr≥region_end, no SRAM access occurs. done rises on the same schedule with data_load=0 and err=1.
- Undefined: err is tied to 0 and no bounds check is performed.

Decomposition:
- Shared package mem_pkg:
  - responder state enum {IDLE, ISSUE, WAIT, COMPLETE}
  - WORD_W=32
  - default ADDR_W
- One sub-module, mem_sram: single-port, synchronous write, READ_LATENCY-stage registered read.

Test Plan:
- Single read: preload addr 0x10=0xDEADBEEF, port 0 avail+r_en with ptr=0x10 → done[0] high after 4 cycles, data_load[0]=0xDEADBEEF; done stays high until avail drops, then clears next edge.
- Write then read: port 3 writes 0x12345678 to 0x20 and drops avail; port 3 then reads 0x20 → data_load[3]=0x12345678.
- Contention: ports 0 and 3 request in the same cycle with rr_ptr=3 → port 0 served first, port 3 completes 4 cycles later; both done high together while both avail remain held.
- Fairness: all 4 ports request continuously, each dropping avail for 1 cycle after its done → grant order is 0,1,2,3,0,…
- Bounds check (macro defined): region [0x100,0x200), write to ptr=0x200 with 0xFFFF → done rises with err=1, and a later read of 0x200 (mod DEPTH) returns its prior value.
- Reset mid-access: assert rst during WAIT → all done=0, FSM=IDLE; after release, a re-issued request completes normally in 4 cycles.
